// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, FSM encoding and request legality check
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Unsigned widths exist only for loads; a store with BU/HU is illegal.
  function automatic logic lsu_req_err(input logic i_we, input logic [2:0] i_f3,
                                       input logic [1:0] i_lsb);
    logic r_err;
    case (i_f3)
      F3_B:    r_err = 1'b0;
      F3_H:    r_err = i_lsb[0];
      F3_W:    r_err = (i_lsb != 2'b00);
      F3_BU:   r_err = i_we;
      F3_HU:   r_err = i_we | i_lsb[0];
      default: r_err = 1'b1;
    endcase
    return r_err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/halfword load extraction and store merge into the buffered word
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  always_comb begin
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{i_word[7]}}, i_word[7:0]};
      F3_BU:   o_load_data = {24'h0, i_word[7:0]};
      F3_H:    o_load_data = {{16{i_word[15]}}, i_word[15:0]};
      F3_HU:   o_load_data = {16'h0, i_word[15:0]};
      default: o_load_data = i_word;
    endcase
  end

  // Narrow stores keep the untouched upper bytes read back during RD.
  always_comb begin
    o_store_data = i_wdata;
    case (i_funct3)
      F3_B:    o_store_data = {i_word[31:8], i_wdata[7:0]};
      F3_H:    o_store_data = {i_word[31:16], i_wdata[15:0]};
      default: o_store_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit with read-modify-write for narrow stores
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  lsu_state_e            r_state;
  lsu_state_e            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  w_accept;
  logic                  w_req_err;
  logic [31:0]           w_load_data;
  logic [31:0]           w_store_data;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_req_err = lsu_req_err(req_we, req_funct3, req_addr[1:0]);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == RD) begin
        r_buf <= mem_data_r;
      end
    end
  end

  lsu_align u_align (
    .i_funct3    (r_f3),
    .i_word      (r_buf),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_store_data(w_store_data)
  );

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    mem_op     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_data_w = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                        w_next = RESP;
          else if (req_we && req_funct3 == F3_W) w_next = WR;
          else                                  w_next = RD;
        end
      end
      RD: begin
        mem_op   = 1'b1;
        mem_addr = r_addr;
        w_next   = r_we ? WR : RESP;
      end
      WR: begin
        mem_op     = 1'b1;
        mem_rw     = 1'b1;
        mem_addr   = r_addr;
        mem_data_w = w_store_data;
        w_next     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_we || r_err) ? '0 : w_load_data;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
